// File: rtl/i2s_pcm_a_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pcm_a_tx
// Description : Slave-mode I2S transmitter for SGTL5000 PCM Format A (DSP
//               mode A). The codec-supplied SCLK, LRCLK and DOUT are
//               oversampled in clk. The optional receiver is enabled by the
//               macro I2S_RX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_pcm_a_tx #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pad_sclk,
    input  logic            pad_lrclk,
    output logic            pad_din,
    input  logic            pad_dout,
    input  logic [BITS-1:0] tx_left,
    input  logic [BITS-1:0] tx_right,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic            underrun,
    output logic [BITS-1:0] rx_left,
    output logic [BITS-1:0] rx_right,
    output logic            rx_valid
);

    localparam int FRAME = 2 * BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } state_t;

    logic sclk_m, sclk_s, sclk_d;
    logic lrclk_m, lrclk_s;
    logic armed;
    logic rise, fall, frame_start, handshake;

    state_t           state;
    logic [FRAME-1:0] hold;
    logic [FRAME-1:0] shreg;
    logic [5:0]       bitcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_m  <= 1'b0;
            sclk_s  <= 1'b0;
            sclk_d  <= 1'b0;
            lrclk_m <= 1'b0;
            lrclk_s <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sclk_m  <= pad_sclk;
            sclk_s  <= sclk_m;
            sclk_d  <= sclk_s;
            lrclk_m <= pad_lrclk;
            lrclk_s <= lrclk_m;
            // A frame sync only counts once it has been seen low, so a sync
            // pulse already in progress at reset release is never taken.
            if (rise && !lrclk_s)
                armed <= 1'b1;
        end
    end

    assign rise        = sclk_s & ~sclk_d;
    assign fall        = ~sclk_s & sclk_d;
    assign frame_start = rise & lrclk_s & armed;
    assign handshake   = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pad_din  <= 1'b0;
            hold     <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            tx_ready <= 1'b1;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (handshake) begin
                hold     <= {tx_left, tx_right};
                tx_ready <= 1'b0;
            end
            if (frame_start) begin
                state <= LOAD;
            end else if (fall) begin
                case (state)
                    LOAD: begin
                        // Copy sees the pre-handshake hold value; an empty
                        // hold simply repeats the previous sample.
                        pad_din  <= hold[FRAME-1];
                        shreg    <= {hold[FRAME-2:0], 1'b0};
                        bitcnt   <= '0;
                        underrun <= tx_ready;
                        tx_ready <= ~handshake;
                        state    <= SHIFT;
                    end
                    SHIFT: begin
                        if (bitcnt == 6'(FRAME - 1)) begin
                            pad_din <= 1'b0;
                            state   <= PAD;
                        end else begin
                            pad_din <= shreg[FRAME-1];
                            shreg   <= {shreg[FRAME-2:0], 1'b0};
                            bitcnt  <= bitcnt + 6'd1;
                        end
                    end
                    default: pad_din <= 1'b0;
                endcase
            end
        end
    end

`ifdef I2S_RX_EN
    logic             dout_m, dout_s;
    logic [FRAME-1:0] rx_sr;
    logic [5:0]       rx_cnt;
    logic             rx_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_m    <= 1'b0;
            dout_s    <= 1'b0;
            rx_sr     <= '0;
            rx_cnt    <= '0;
            rx_active <= 1'b0;
            rx_left   <= '0;
            rx_right  <= '0;
            rx_valid  <= 1'b0;
        end else begin
            dout_m   <= pad_dout;
            dout_s   <= dout_m;
            rx_valid <= 1'b0;
            if (frame_start) begin
                // A new sync discards any partially captured word.
                rx_active <= 1'b1;
                rx_cnt    <= '0;
            end else if (rise && rx_active) begin
                rx_sr <= {rx_sr[FRAME-2:0], dout_s};
                if (rx_cnt == 6'(FRAME - 1)) begin
                    rx_left   <= rx_sr[FRAME-2:BITS-1];
                    rx_right  <= {rx_sr[BITS-2:0], dout_s};
                    rx_valid  <= 1'b1;
                    rx_active <= 1'b0;
                end else begin
                    rx_cnt <= rx_cnt + 6'd1;
                end
            end
        end
    end
`else
    logic unused_dout;
    assign unused_dout = pad_dout;
    assign rx_left     = '0;
    assign rx_right    = '0;
    assign rx_valid    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_pcm_a_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_pcm_a_tx
// Description : Directed bench for i2s_pcm_a_tx; models the codec side of a
//               64-SCLK DSP-mode-A frame. RX checks follow I2S_RX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_pcm_a_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pad_sclk = 1'b0;
    logic        pad_lrclk = 1'b0;
    logic        pad_din;
    logic        pad_dout = 1'b0;
    logic [15:0] tx_left = '0;
    logic [15:0] tx_right = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        underrun;
    logic [15:0] rx_left;
    logic [15:0] rx_right;
    logic        rx_valid;

    int checks = 0;
    int errors = 0;
    int ur_cnt = 0;
    int rx_cnt = 0;
    int hs_cnt = 0;
    logic [15:0] rx_l_seen = '0;
    logic [15:0] rx_r_seen = '0;
    logic        din_after_rst;
    logic        stream_en = 1'b0;
    logic [15:0] next_val = '0;

    i2s_pcm_a_tx #(.BITS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .pad_sclk  (pad_sclk),
        .pad_lrclk (pad_lrclk),
        .pad_din   (pad_din),
        .pad_dout  (pad_dout),
        .tx_left   (tx_left),
        .tx_right  (tx_right),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .underrun  (underrun),
        .rx_left   (rx_left),
        .rx_right  (rx_right),
        .rx_valid  (rx_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (underrun) ur_cnt++;
        if (tx_valid && tx_ready) hs_cnt++;
        if (rx_valid) begin
            rx_cnt++;
            rx_l_seen = rx_left;
            rx_r_seen = rx_right;
        end
    end

    // Counter-pattern source: advances the sample after every handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (stream_en && tx_valid && tx_ready) begin
                @(posedge clk);
                #1;
                next_val = next_val + 16'd1;
                tx_left  = next_val;
                tx_right = ~next_val;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One codec frame: lrclk high for SCLK 0, dout driven on falls, pad_din
    // captured on rises (cap[i] holds the data bit sent after sync bit i-1).
    task automatic run_frame(input int n, input logic [31:0] rxw, input int rst_at,
                             output logic [63:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            pad_sclk  = 1'b0;
            pad_lrclk = (i == 0);
            pad_dout  = (i >= 1 && i <= 32) ? rxw[32-i] : 1'b0;
            if (i == rst_at) begin
                #30; rst = 1'b1;
                #10; din_after_rst = pad_din;
                pad_sclk = 1'b1; cap[i] = pad_din;
                #10; rst = 1'b0;
                #30;
            end else begin
                #40; pad_sclk = 1'b1; cap[i] = pad_din;
                #40;
            end
        end
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) begin
            pad_sclk = 1'b0; pad_lrclk = 1'b0; pad_dout = 1'b0;
            #40; pad_sclk = 1'b1;
            #40;
        end
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        tx_left = l; tx_right = r; tx_valid = 1'b1;
        for (int k = 0; k < 2000 && !tx_ready; k++) begin
            @(posedge clk); #1;
        end
        check("send_ready", {63'd0, tx_ready}, 64'd1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("hold_full", {63'd0, tx_ready}, 64'd0);
    endtask

    function automatic logic [31:0] bits_of(input logic [63:0] c, input int first, input int n);
        logic [31:0] w = '0;
        for (int k = 0; k < n; k++) w = {w[30:0], c[first+k]};
        return w;
    endfunction

    logic [63:0] cap;
    int ur0, rx0, hs0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_din",      {63'd0, pad_din},  64'd0);
        check("rst_ready",    {63'd0, tx_ready}, 64'd1);
        check("rst_underrun", {63'd0, underrun}, 64'd0);
        check("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
        check("rst_rx_data",  {32'd0, rx_left, rx_right}, 64'd0);
        rst = 1'b0;
        idle_bits(4);

        // Basic frame
        ur0 = ur_cnt;
        send(16'hA55A, 16'h0F0F);
        run_frame(64, 32'd0, -1, cap);
        check("basic_word",  {32'd0, bits_of(cap, 1, 32)}, {32'd0, 32'hA55A0F0F});
        check("basic_tail",  {33'd0, cap[63:33]}, 64'd0);
        check("basic_ready", {63'd0, tx_ready}, 64'd1);
        check("basic_no_ur", 64'(ur_cnt - ur0), 64'd0);

        // Underrun: two frames without new data repeat the last sample
        send(16'h8001, 16'h7FFE);
        ur0 = ur_cnt;
        run_frame(64, 32'd0, -1, cap);
        check("ur_word0", {32'd0, bits_of(cap, 1, 32)}, {32'd0, 32'h80017FFE});
        run_frame(64, 32'd0, -1, cap);
        check("ur_word1", {32'd0, bits_of(cap, 1, 32)}, {32'd0, 32'h80017FFE});
        run_frame(64, 32'd0, -1, cap);
        check("ur_word2", {32'd0, bits_of(cap, 1, 32)}, {32'd0, 32'h80017FFE});
        check("ur_count", 64'(ur_cnt - ur0), 64'd2);

        // Short frame: sync re-asserted after 20 SCLKs
        send(16'hC3C3, 16'h3C3C);
        rx0 = rx_cnt;
        run_frame(20, 32'hFFFFFFFF, -1, cap);
        check("short_bits", {32'd0, bits_of(cap, 1, 19)}, {32'd0, 32'hC3C33C3C >> 13});
        check("short_no_rx", 64'(rx_cnt - rx0), 64'd0);
        ur0 = ur_cnt;
        run_frame(64, 32'd0, -1, cap);
        check("short_restart", {32'd0, bits_of(cap, 1, 32)}, {32'd0, 32'hC3C33C3C});
        check("short_tail",    {33'd0, cap[63:33]}, 64'd0);
        check("short_ur",      64'(ur_cnt - ur0), 64'd1);

        // Reset at bit 10 of the left word
        send(16'hFFFF, 16'hFFFF);
        run_frame(64, 32'd0, 11, cap);
        check("rst_mid_head",  {32'd0, bits_of(cap, 1, 10)}, 64'h3FF);
        check("rst_mid_din",   {63'd0, din_after_rst}, 64'd0);
        check("rst_mid_rest",  {11'd0, cap[63:11]}, 64'd0);
        check("rst_mid_ready", {63'd0, tx_ready}, 64'd1);
        ur0 = ur_cnt;
        run_frame(64, 32'd0, -1, cap);
        check("post_rst_zero", cap, 64'd0);
        check("post_rst_ur",   64'(ur_cnt - ur0), 64'd1);

        // Receive path
        rx0 = rx_cnt;
        run_frame(64, 32'h1234FEDC, -1, cap);
`ifdef I2S_RX_EN
        check("rx_pulses", 64'(rx_cnt - rx0), 64'd1);
        check("rx_data",   {32'd0, rx_l_seen, rx_r_seen}, {32'd0, 32'h1234FEDC});
`else
        check("rx_pulses",  64'(rx_cnt - rx0), 64'd0);
        check("rx_tied",    {32'd0, rx_left, rx_right}, 64'd0);
`endif

        // tx_valid held high: one handshake per frame, counter pattern
        hs0 = hs_cnt;
        ur0 = ur_cnt;
        next_val = 16'h0100;
        tx_left  = next_val;
        tx_right = ~next_val;
        stream_en = 1'b1;
        tx_valid  = 1'b1;
        for (int f = 0; f < 100; f++) begin
            logic [15:0] e;
            e = 16'h0100 + 16'(f);
            run_frame(64, 32'd0, -1, cap);
            check("stream_word", {32'd0, bits_of(cap, 1, 32)}, {32'd0, e, ~e});
        end
        stream_en = 1'b0;
        tx_valid  = 1'b0;
        check("stream_hs", 64'(hs_cnt - hs0), 64'd101);
        check("stream_ur", 64'(ur_cnt - ur0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
